// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared predictor types and saturating counter helper
package ariane_pkg;

    localparam int unsigned GP_MAX_PC_W  = 64;
    localparam int unsigned GP_MAX_GHR_W = 16;
    localparam int unsigned GP_MAX_CTR_W = 8;

    typedef struct packed {
        logic [GP_MAX_PC_W-1:0]  pc;
        logic [GP_MAX_GHR_W-1:0] ghr;
        logic                    taken;
        logic                    mispredict;
    } gp_update_t;

    typedef enum logic {
        GP_INIT,
        GP_READY
    } gp_state_e;

    // Saturating up/down step for a counter of cb bits, carried zero-extended.
    function automatic logic [GP_MAX_CTR_W-1:0] gp_ctr_next(
        input logic [GP_MAX_CTR_W-1:0] ctr,
        input logic                    taken,
        input int unsigned             cb
    );
        logic [GP_MAX_CTR_W-1:0] max_v;
        max_v = GP_MAX_CTR_W'((1 << cb) - 1);
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 8'd1;
        end
        return (ctr == '0) ? '0 : ctr - 8'd1;
    endfunction

endpackage

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - derived core configuration consumed by the direction predictor
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned GlobalPredictorIndexBits;
        int unsigned GlobalCtrBits;
        int unsigned GlobalPredictorSize;
        int unsigned INSTR_PER_FETCH;
        int unsigned FETCH_ALIGN_BITS;
        bit          RVC;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        VLEN:                     32,
        GlobalPredictorIndexBits: 8,
        GlobalCtrBits:            2,
        GlobalPredictorSize:      256,
        INSTR_PER_FETCH:          2,
        FETCH_ALIGN_BITS:         2,
        RVC:                      1'b1
    };

endpackage

// File: rtl/global_pht.sv
// rtl/global_pht.sv - pattern history table flop array with read, RMW and row-clear ports
module global_pht
    import ariane_pkg::*;
#(
    parameter int unsigned IB  = 8,
    parameter int unsigned IPF = 2,
    parameter int unsigned CB  = 2,
    parameter int unsigned SW  = 1
) (
    input  logic                clk_i,
    input  logic                rd_en_i,
    input  logic [IB-1:0]       rd_idx_i,
    output logic [IPF*CB-1:0]   rd_row_o,
    input  logic                upd_en_i,
    input  logic [IB-1:0]       upd_idx_i,
    input  logic [SW-1:0]       upd_slot_i,
    input  logic                upd_taken_i,
    input  logic                clr_en_i,
    input  logic [IB-1:0]       clr_idx_i,
    input  logic [CB-1:0]       clr_val_i
);

    localparam int unsigned ROWS = 1 << IB;
    localparam int unsigned RW   = IPF * CB;

    logic [RW-1:0] rows_q [ROWS];
    logic [CB-1:0] upd_cur;
    logic [CB-1:0] upd_new;
    logic [GP_MAX_CTR_W-1:0] upd_wide;
    int unsigned   upd_lsb;

    // Pick the addressed counter and compute its saturated successor.
    always_comb begin
        upd_lsb  = int'(upd_slot_i) * CB;
        upd_cur  = rows_q[upd_idx_i][upd_lsb +: CB];
        upd_wide = gp_ctr_next(GP_MAX_CTR_W'(upd_cur), upd_taken_i, CB);
        upd_new  = upd_wide[CB-1:0];
    end

    // Registered read; sees the row as it was before any same-edge write.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_row_o <= rows_q[rd_idx_i];
        end
    end

    // Row clear during initialisation, otherwise single-counter update.
    always_ff @(posedge clk_i) begin
        if (clr_en_i) begin
            rows_q[clr_idx_i] <= {IPF{clr_val_i}};
        end else if (upd_en_i) begin
            rows_q[upd_idx_i][upd_lsb +: CB] <= upd_new;
        end
    end

    logic unused_ctr_hi;
    assign unused_ctr_hi = ^upd_wide;

endmodule

// File: rtl/global_history_predictor.sv
// rtl/global_history_predictor.sv - gshare direction predictor with speculative GHR and init sweep
module global_history_predictor
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    output logic                                         ready_o,
    input  logic                                         lookup_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]                      lookup_vpc_i,
    output logic                                         predict_valid_o,
    output logic [CVA6Cfg.INSTR_PER_FETCH-1:0]           predict_taken_o,
    output logic [CVA6Cfg.GlobalPredictorIndexBits-1:0]  predict_ghr_o,
    input  logic                                         spec_valid_i,
    input  logic                                         spec_taken_i,
    input  logic                                         update_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]                      update_pc_i,
    input  logic [CVA6Cfg.GlobalPredictorIndexBits-1:0]  update_ghr_i,
    input  logic                                         update_taken_i,
    input  logic                                         update_mispredict_i
);

    localparam int unsigned IB       = CVA6Cfg.GlobalPredictorIndexBits;
    localparam int unsigned CB       = CVA6Cfg.GlobalCtrBits;
    localparam int unsigned IPF      = CVA6Cfg.INSTR_PER_FETCH;
    localparam int unsigned FAB      = CVA6Cfg.FETCH_ALIGN_BITS;
    localparam int unsigned RW       = IPF * CB;
    localparam int unsigned SW       = (IPF > 1) ? $clog2(IPF) : 1;
    localparam int unsigned SLOT_LSB = CVA6Cfg.RVC ? 1 : 2;
    localparam logic [CB-1:0] CTR_WEAK_NT = CB'((1 << (CB - 1)) - 1);

    gp_state_e            state_q;
    logic                 ready_q;
    logic [IB-1:0]        ptr_q;
    logic [IB-1:0]        ghr_q;
    logic                 look_ready_q;
    logic [IB-1:0]        lookup_idx;
    logic [IB-1:0]        update_idx;
    logic [SW-1:0]        update_slot;
    logic [CVA6Cfg.VLEN-1:0] slot_field;
    logic [RW-1:0]        pht_row;
    gp_update_t           upd;

    assign upd.pc         = GP_MAX_PC_W'(update_pc_i);
    assign upd.ghr        = GP_MAX_GHR_W'(update_ghr_i);
    assign upd.taken      = update_taken_i;
    assign upd.mispredict = update_mispredict_i;

    assign lookup_idx  = lookup_vpc_i[IB+FAB-1:FAB] ^ ghr_q;
    assign update_idx  = update_pc_i[IB+FAB-1:FAB] ^ upd.ghr[IB-1:0];
    assign slot_field  = update_pc_i >> SLOT_LSB;
    assign update_slot = (IPF > 1) ? slot_field[SW-1:0] : '0;
    assign ready_o     = ready_q;

    // Init sweep: clear one row per cycle, then stay ready until the next reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= GP_INIT;
            ready_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                GP_INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (&ptr_q) begin
                        state_q <= GP_READY;
                        ready_q <= 1'b1;
                    end
                end
                GP_READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= GP_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // History: a mispredict restore overrides any speculative shift that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q <= '0;
        end else if (update_valid_i && upd.mispredict) begin
            ghr_q <= {upd.ghr[IB-2:0], upd.taken};
        end else if (spec_valid_i) begin
            ghr_q <= {ghr_q[IB-2:0], spec_taken_i};
        end
    end

    // Prediction side-band: valid pulse, GHR snapshot, and whether the table was usable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            predict_valid_o <= 1'b0;
            predict_ghr_o   <= '0;
            look_ready_q    <= 1'b0;
        end else begin
            predict_valid_o <= lookup_valid_i;
            look_ready_q    <= lookup_valid_i && (state_q == GP_READY);
            if (lookup_valid_i) begin
                predict_ghr_o <= ghr_q;
            end
        end
    end

    // Taken bit per slot is the counter MSB; forced low for lookups issued during init.
    always_comb begin
        predict_taken_o = '0;
        for (int i = 0; i < IPF; i++) begin
            predict_taken_o[i] = look_ready_q & pht_row[i*CB + CB - 1];
        end
    end

    global_pht #(
        .IB  (IB),
        .IPF (IPF),
        .CB  (CB),
        .SW  (SW)
    ) u_pht (
        .clk_i       (clk_i),
        .rd_en_i     (lookup_valid_i),
        .rd_idx_i    (lookup_idx),
        .rd_row_o    (pht_row),
        .upd_en_i    (update_valid_i && (state_q == GP_READY)),
        .upd_idx_i   (update_idx),
        .upd_slot_i  (update_slot),
        .upd_taken_i (update_taken_i),
        .clr_en_i    (state_q == GP_INIT),
        .clr_idx_i   (ptr_q),
        .clr_val_i   (CTR_WEAK_NT)
    );

    logic unused_bits;
    assign unused_bits = ^{lookup_vpc_i, update_pc_i, slot_field, upd.pc, upd.ghr, upd.mispredict};

endmodule

// File: tb/tb_global_history_predictor.sv
// tb/tb_global_history_predictor.sv - randomized and directed check against a table model
module tb_global_history_predictor;

    localparam config_pkg::cva6_cfg_t CFG = '{
        VLEN:                     32,
        GlobalPredictorIndexBits: 8,
        GlobalCtrBits:            2,
        GlobalPredictorSize:      256,
        INSTR_PER_FETCH:          2,
        FETCH_ALIGN_BITS:         2,
        RVC:                      1'b1
    };

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ready_o;
    logic        lookup_valid_i;
    logic [31:0] lookup_vpc_i;
    logic        predict_valid_o;
    logic [1:0]  predict_taken_o;
    logic [7:0]  predict_ghr_o;
    logic        spec_valid_i;
    logic        spec_taken_i;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic [7:0]  update_ghr_i;
    logic        update_taken_i;
    logic        update_mispredict_i;

    global_history_predictor #(.CVA6Cfg(CFG)) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .ready_o             (ready_o),
        .lookup_valid_i      (lookup_valid_i),
        .lookup_vpc_i        (lookup_vpc_i),
        .predict_valid_o     (predict_valid_o),
        .predict_taken_o     (predict_taken_o),
        .predict_ghr_o       (predict_ghr_o),
        .spec_valid_i        (spec_valid_i),
        .spec_taken_i        (spec_taken_i),
        .update_valid_i      (update_valid_i),
        .update_pc_i         (update_pc_i),
        .update_ghr_i        (update_ghr_i),
        .update_taken_i      (update_taken_i),
        .update_mispredict_i (update_mispredict_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: counters per row/slot, history as an integer, rows swept so far.
    int m_pht [256][2];
    int m_ghr   = 0;
    int m_swept = 0;
    int e_valid = 0;
    int e_taken = 0;
    int e_ghr   = 0;
    int e_rst   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        lookup_valid_i      = 1'b0;
        lookup_vpc_i        = '0;
        spec_valid_i        = 1'b0;
        spec_taken_i        = 1'b0;
        update_valid_i      = 1'b0;
        update_pc_i         = '0;
        update_ghr_i        = '0;
        update_taken_i      = 1'b0;
        update_mispredict_i = 1'b0;
    endtask

    task automatic randomize_inputs();
        lookup_valid_i      = 1'($urandom_range(0, 1));
        lookup_vpc_i        = 32'($urandom_range(0, 127));
        spec_valid_i        = 1'($urandom_range(0, 1));
        spec_taken_i        = 1'($urandom_range(0, 1));
        update_valid_i      = 1'($urandom_range(0, 1));
        update_pc_i         = 32'($urandom_range(0, 31));
        update_ghr_i        = 8'($urandom_range(0, 3));
        update_taken_i      = 1'($urandom_range(0, 1));
        update_mispredict_i = ($urandom_range(0, 3) == 0);
    endtask

    // Advance one clock: model the edge from the current inputs, then compare outputs.
    task automatic step();
        int lidx;
        int uidx;
        int uslot;
        e_rst   = rst_i;
        e_valid = rst_i ? 0 : lookup_valid_i;
        e_taken = 0;
        if (rst_i) begin
            e_ghr = 0;
        end else if (lookup_valid_i) begin
            lidx = ((int'(lookup_vpc_i) / 4) % 256) ^ m_ghr;
            if (m_swept == 256) begin
                for (int s = 0; s < 2; s++) begin
                    if (m_pht[lidx][s] >= 2) e_taken += (1 << s);
                end
            end
            e_ghr = m_ghr;
        end
        if (rst_i) begin
            m_swept = 0;
            m_ghr   = 0;
        end else begin
            if (m_swept < 256) begin
                m_pht[m_swept][0] = 1;
                m_pht[m_swept][1] = 1;
                m_swept++;
            end else if (update_valid_i) begin
                uidx  = ((int'(update_pc_i) / 4) % 256) ^ int'(update_ghr_i);
                uslot = (int'(update_pc_i) / 2) % 2;
                if (update_taken_i) begin
                    if (m_pht[uidx][uslot] < 3) m_pht[uidx][uslot]++;
                end else begin
                    if (m_pht[uidx][uslot] > 0) m_pht[uidx][uslot]--;
                end
            end
            if (update_valid_i && update_mispredict_i) begin
                m_ghr = (int'(update_ghr_i) * 2 + int'(update_taken_i)) % 256;
            end else if (spec_valid_i) begin
                m_ghr = (m_ghr * 2 + int'(spec_taken_i)) % 256;
            end
        end
        @(posedge clk);
        #1;
        check("ready", 32'(ready_o), 32'(m_swept == 256 ? 1 : 0));
        check("valid", 32'(predict_valid_o), 32'(e_valid));
        if (e_valid != 0 || e_rst != 0) begin
            check("taken", 32'(predict_taken_o), 32'(e_taken));
            check("ghr", 32'(predict_ghr_o), 32'(e_ghr));
        end
    endtask

    task automatic lookup_only(input logic [31:0] vpc);
        idle();
        lookup_valid_i = 1'b1;
        lookup_vpc_i   = vpc;
        step();
    endtask

    task automatic set_ghr(input logic [7:0] g);
        idle();
        update_valid_i      = 1'b1;
        update_mispredict_i = 1'b1;
        update_pc_i         = 32'h0000_1000;
        update_ghr_i        = {1'b0, g[7:1]};
        update_taken_i      = g[0];
        step();
    endtask

    task automatic count_init(input string tag);
        int n;
        n = 0;
        rst_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            step();
            n++;
            if (ready_o) break;
        end
        check(tag, 32'(n), 32'd256);
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("reset_ready", 32'(ready_o), 32'd0);
        check("reset_taken", 32'(predict_taken_o), 32'd0);
        count_init("init_len");

        // Freshly cleared table predicts not-taken everywhere.
        set_ghr(8'h00);
        for (int i = 0; i < 16; i++) begin
            lookup_only(32'($urandom_range(0, 1023)));
            check("clean_row", 32'(predict_taken_o), 32'd0);
        end

        // Saturation: three taken updates on pc 0x104 with GHR 0.
        set_ghr(8'h00);
        for (int i = 0; i < 3; i++) begin
            idle();
            update_valid_i = 1'b1;
            update_pc_i    = 32'h104;
            update_taken_i = 1'b1;
            step();
        end
        lookup_only(32'h104);
        check("sat_ghr", 32'(predict_ghr_o), 32'h00);

        // Speculative shifts 1,0,1 give history 0x05.
        set_ghr(8'h00);
        for (int i = 0; i < 3; i++) begin
            idle();
            spec_valid_i = 1'b1;
            spec_taken_i = (i != 1);
            step();
        end
        lookup_only(32'h014);
        check("spec_ghr", 32'(predict_ghr_o), 32'h05);

        // Restore beats a same-cycle speculative shift.
        idle();
        spec_valid_i        = 1'b1;
        spec_taken_i        = 1'b0;
        update_valid_i      = 1'b1;
        update_mispredict_i = 1'b1;
        update_pc_i         = 32'h2000;
        update_ghr_i        = 8'hA0;
        update_taken_i      = 1'b1;
        step();
        lookup_only(32'h0);
        check("restore_ghr", 32'(predict_ghr_o), 32'h41);

        // Same-cycle update and lookup of row 0x10 returns the old counter.
        set_ghr(8'h00);
        idle();
        lookup_valid_i = 1'b1;
        lookup_vpc_i   = 32'h40;
        update_valid_i = 1'b1;
        update_pc_i    = 32'h40;
        update_taken_i = 1'b1;
        step();
        check("rmw_old", 32'(predict_taken_o), 32'd0);
        lookup_only(32'h40);
        check("rmw_new", 32'(predict_taken_o), 32'd1);

        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            step();
        end

        // Reset in the middle of the sweep restarts it from row 0.
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            randomize_inputs();
            step();
        end
        randomize_inputs();
        rst_i = 1'b1;
        step();
        check("midreset_valid", 32'(predict_valid_o), 32'd0);
        check("midreset_ghr", 32'(predict_ghr_o), 32'd0);
        count_init("reinit_len");
        for (int i = 0; i < 200; i++) begin
            randomize_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
